exu_ctrl: RTL and testbench
===========================

// Module: exu_ctrl
// PURPOSE
//   Sequencing controller for the execute stage. Accepts one decoded op from IDU (valid/ready),
//   registers its operands and drives them to the combinational fu (1-cycle path) or to an
//   iterative mul/div unit (start/done path), then holds the result until WBU accepts it.
//   Sits between idu and wbu. Owns the only registers of the EXU.
// PARAMETERS
//   DATA_W      32   operand/result width (matches `REG_DATA_BUS)
//   MD_TIMEOUT  64   max cycles to wait for md_done_i before forcing completion
//   CNT_W       7    wait-counter width; must hold MD_TIMEOUT
// PORTS
//   clk            in   1              clock; all state updates on rising edge
//   rst            in   1              synchronous reset, active-high (`RST_ENABLE)
//   flush_i        in   1              discard in-flight op (redirect)
//   idu_valid_i    in   1              IDU presents an op
//   exu_ready_o    out  1              EXU can accept an op this cycle
//   is_md_i        in   1              op uses the mul/div unit
//   inst_type_i    in   `INST_TYPE_BUS decoded instruction type
//   alu_op_i       in   `ALU_OP_BUS    decoded ALU op
//   pc_i           in   `INST_ADDR_BUS pc of op
//   imm_i/rdata1_i/rdata2_i in DATA_W  immediate / rs1 / rs2 data
//   fu_inst_type_o/fu_alu_op_o/fu_pc_o/fu_imm_o/fu_rdata1_o/fu_rdata2_o out  latched op to fu / md unit
//   fu_result_i    in   DATA_W         fu combinational result
//   md_start_o     out  1              one-cycle start pulse to mul/div
//   md_kill_o      out  1              one-cycle abort pulse to mul/div
//   md_done_i      in   1              mul/div result valid (single-cycle pulse)
//   md_result_i    in   DATA_W         mul/div result
//   wbu_valid_o    out  1              result_o valid for WBU
//   wbu_ready_i    in   1              WBU accepts
//   result_o       out  DATA_W         registered result
//   timeout_o      out  1              result_o was forced by timeout (valid with wbu_valid_o)
// BEHAVIOUR
//   States: IDLE, ALU, MD_WAIT, DONE. Reset -> IDLE; all latched op regs, result_o, counter = 0;
//     exu_ready_o=1, wbu_valid_o/md_start_o/md_kill_o/timeout_o=0. fu_inst_type_o=`INST_NOP.
//   exu_ready_o = (state==IDLE) && !flush_i. Handshake = idu_valid_i && exu_ready_o.
//   IDLE: on handshake latch all op inputs; -> MD_WAIT if is_md_i else ALU. Else stay.
//   ALU: result_o <= fu_result_i, timeout_o <= 0; -> DONE. Op latency accept->valid = 2 cycles.
//   MD_WAIT: md_start_o=1 only on first cycle in state; counter clears on entry, +1 each cycle.
//     md_done_i (any cycle incl. first) -> result_o <= md_result_i, timeout_o <= 0, -> DONE.
//     counter == MD_TIMEOUT-1 without done -> result_o <= 0, timeout_o <= 1, md_kill_o=1 that
//     cycle, -> DONE. done and timeout same cycle: done wins, no kill.
//   DONE: wbu_valid_o=1; result_o/timeout_o stable while !wbu_ready_i; on wbu_ready_i -> IDLE.
//     No accept in DONE (max throughput 1 op / 3 cycles on ALU path).
//   flush_i: highest priority except rst; next state IDLE, wbu_valid_o drops next cycle, no WBU
//     handshake completes in a flush cycle. Flush in MD_WAIT asserts md_kill_o that cycle;
//     md_done_i arriving with flush is ignored. Flush in IDLE blocks accept.
//   NOP ops (`INST_NOP or `ALU_OP_NOP) take the ALU path normally and return 0 from fu.
//   rst mid-operation: immediate return to reset values next edge; no kill pulse issued.
//   Counter saturates; never wraps.
// TESTING
//   1 ADD x1=5,x2=7 RR, wbu_ready_i=1 -> ready drops next cycle; wbu_valid_o 2 cycles after accept, result_o=12, back to IDLE next.
//   2 ALU op with wbu_ready_i=0 for 5 cycles -> result_o/wbu_valid_o held 5 cycles, exu_ready_o=0 throughout.
//   3 is_md_i=1, md_done_i after 10 cycles, md_result_i=0xDEAD_BEEF -> single md_start_o pulse, result_o=0xDEADBEEF, timeout_o=0.
//   4 is_md_i=1, md_done_i never -> md_kill_o at cycle 63 of MD_WAIT, result_o=0, timeout_o=1.
//   5 flush_i in MD_WAIT and in DONE -> md_kill_o pulse (MD_WAIT only), IDLE next cycle, no wbu handshake.
//   6 rst during MD_WAIT, then AUIPC pc=0x8000_0000 imm=0x1000 -> clean restart, result_o=0x8000_1000.

Source files
------------

// File: rtl/exu_ctrl.sv
// Execute-stage sequencer: latches one IDU op, runs it through the 1-cycle fu or the
// iterative mul/div unit (with timeout), and holds the result until WBU takes it.
module exu_ctrl #(
  parameter int unsigned            DATA_W      = 32,
  parameter int unsigned            MD_TIMEOUT  = 64,
  parameter int unsigned            CNT_W       = 7,
  parameter int unsigned            INST_TYPE_W = 4,
  parameter int unsigned            ALU_OP_W    = 5,
  parameter int unsigned            ADDR_W      = 32,
  parameter logic [INST_TYPE_W-1:0] INST_NOP    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   idu_valid_i,
  output logic                   exu_ready_o,
  input  logic                   is_md_i,
  input  logic [INST_TYPE_W-1:0] inst_type_i,
  input  logic [ALU_OP_W-1:0]    alu_op_i,
  input  logic [ADDR_W-1:0]      pc_i,
  input  logic [DATA_W-1:0]      imm_i,
  input  logic [DATA_W-1:0]      rdata1_i,
  input  logic [DATA_W-1:0]      rdata2_i,
  output logic [INST_TYPE_W-1:0] fu_inst_type_o,
  output logic [ALU_OP_W-1:0]    fu_alu_op_o,
  output logic [ADDR_W-1:0]      fu_pc_o,
  output logic [DATA_W-1:0]      fu_imm_o,
  output logic [DATA_W-1:0]      fu_rdata1_o,
  output logic [DATA_W-1:0]      fu_rdata2_o,
  input  logic [DATA_W-1:0]      fu_result_i,
  output logic                   md_start_o,
  output logic                   md_kill_o,
  input  logic                   md_done_i,
  input  logic [DATA_W-1:0]      md_result_i,
  output logic                   wbu_valid_o,
  input  logic                   wbu_ready_i,
  output logic [DATA_W-1:0]      result_o,
  output logic                   timeout_o
);

  typedef enum logic [1:0] {S_IDLE, S_ALU, S_MD_WAIT, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [INST_TYPE_W-1:0] type_q, type_d;
  logic [ALU_OP_W-1:0]    op_q, op_d;
  logic [ADDR_W-1:0]      pc_q, pc_d;
  logic [DATA_W-1:0]      imm_q, imm_d;
  logic [DATA_W-1:0]      rs1_q, rs1_d;
  logic [DATA_W-1:0]      rs2_q, rs2_d;
  logic [DATA_W-1:0]      result_q, result_d;
  logic                   timeout_q, timeout_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   md_start, md_kill;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      type_q    <= INST_NOP;
      op_q      <= '0;
      pc_q      <= '0;
      imm_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      result_q  <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      op_q      <= op_d;
      pc_q      <= pc_d;
      imm_q     <= imm_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    op_d      = op_q;
    pc_d      = pc_q;
    imm_d     = imm_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    result_d  = result_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    md_start  = 1'b0;
    md_kill   = 1'b0;

    // Flush overrides everything; a done arriving in the same cycle is dropped.
    if (flush_i) begin
      state_d = S_IDLE;
      md_kill = (state_q == S_MD_WAIT);
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (idu_valid_i) begin
            type_d  = inst_type_i;
            op_d    = alu_op_i;
            pc_d    = pc_i;
            imm_d   = imm_i;
            rs1_d   = rdata1_i;
            rs2_d   = rdata2_i;
            cnt_d   = '0;
            state_d = is_md_i ? S_MD_WAIT : S_ALU;
          end
        end
        S_ALU: begin
          result_d  = fu_result_i;
          timeout_d = 1'b0;
          state_d   = S_DONE;
        end
        S_MD_WAIT: begin
          md_start = (cnt_q == '0);
          if (md_done_i) begin
            result_d  = md_result_i;
            timeout_d = 1'b0;
            state_d   = S_DONE;
          end else if (cnt_q == CNT_W'(MD_TIMEOUT - 1)) begin
            result_d  = '0;
            timeout_d = 1'b1;
            md_kill   = 1'b1;
            state_d   = S_DONE;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          if (wbu_ready_i) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign exu_ready_o    = (state_q == S_IDLE) && !flush_i;
  assign wbu_valid_o    = (state_q == S_DONE);
  assign md_start_o     = md_start && !rst;
  assign md_kill_o      = md_kill && !rst;
  assign result_o       = result_q;
  assign timeout_o      = timeout_q;
  assign fu_inst_type_o = type_q;
  assign fu_alu_op_o    = op_q;
  assign fu_pc_o        = pc_q;
  assign fu_imm_o       = imm_q;
  assign fu_rdata1_o    = rs1_q;
  assign fu_rdata2_o    = rs2_q;

endmodule

// File: tb/tb_exu_ctrl.sv
// Bench for exu_ctrl: directed scenarios plus randomized ops against a transaction-level model.
module tb_exu_ctrl;

  localparam int unsigned MD_TO = 64;

  localparam logic [3:0] T_NOP = 4'd0, T_RR = 4'd1, T_AUIPC = 4'd2;
  localparam logic [4:0] A_NOP = 5'd0, A_ADD = 5'd1, A_SUB = 5'd2, A_XOR = 5'd3;
  localparam int FL_NONE = -1, FL_DONE = 1000;

  logic        clk = 1'b0;
  logic        rst, flush_i, idu_valid_i, exu_ready_o, is_md_i;
  logic [3:0]  inst_type_i, fu_inst_type_o;
  logic [4:0]  alu_op_i, fu_alu_op_o;
  logic [31:0] pc_i, imm_i, rdata1_i, rdata2_i;
  logic [31:0] fu_pc_o, fu_imm_o, fu_rdata1_o, fu_rdata2_o, fu_result_i;
  logic        md_start_o, md_kill_o, md_done_i, wbu_valid_o, wbu_ready_i, timeout_o;
  logic [31:0] md_result_i, result_o;

  int n_vec = 0;
  int n_err = 0;

  exu_ctrl #(.DATA_W(32), .MD_TIMEOUT(MD_TO), .CNT_W(7), .INST_TYPE_W(4),
             .ALU_OP_W(5), .ADDR_W(32), .INST_NOP(T_NOP)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .idu_valid_i(idu_valid_i),
    .exu_ready_o(exu_ready_o), .is_md_i(is_md_i), .inst_type_i(inst_type_i),
    .alu_op_i(alu_op_i), .pc_i(pc_i), .imm_i(imm_i), .rdata1_i(rdata1_i),
    .rdata2_i(rdata2_i), .fu_inst_type_o(fu_inst_type_o), .fu_alu_op_o(fu_alu_op_o),
    .fu_pc_o(fu_pc_o), .fu_imm_o(fu_imm_o), .fu_rdata1_o(fu_rdata1_o),
    .fu_rdata2_o(fu_rdata2_o), .fu_result_i(fu_result_i), .md_start_o(md_start_o),
    .md_kill_o(md_kill_o), .md_done_i(md_done_i), .md_result_i(md_result_i),
    .wbu_valid_o(wbu_valid_o), .wbu_ready_i(wbu_ready_i), .result_o(result_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  // Stand-in combinational fu driven by the latched operands.
  always_comb begin
    fu_result_i = '0;
    if (fu_inst_type_o == T_AUIPC) fu_result_i = fu_pc_o + fu_imm_o;
    else if (fu_inst_type_o == T_RR) begin
      case (fu_alu_op_o)
        A_ADD:   fu_result_i = fu_rdata1_o + fu_rdata2_o;
        A_SUB:   fu_result_i = fu_rdata1_o - fu_rdata2_o;
        A_XOR:   fu_result_i = fu_rdata1_o ^ fu_rdata2_o;
        default: fu_result_i = '0;
      endcase
    end
  end

  function automatic logic [31:0] ref_result(input logic [3:0] it, input logic [4:0] op,
                                             input logic [31:0] pc, imm, a, b);
    if (it == T_NOP || op == A_NOP) return 32'd0;
    if (it == T_AUIPC) return pc + imm;
    if (op == A_ADD) return a + b;
    if (op == A_SUB) return a - b;
    if (op == A_XOR) return a ^ b;
    return 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic scramble();
    is_md_i     = 1'($urandom_range(0, 1));
    inst_type_i = 4'($urandom_range(0, 15));
    alu_op_i    = 5'($urandom_range(0, 31));
    pc_i        = $urandom;
    imm_i       = $urandom;
    rdata1_i    = $urandom;
    rdata2_i    = $urandom;
  endtask

  // One op from accept to writeback. dly = md_done delay in MD_WAIT cycles (>= MD_TO: never).
  // fl: FL_NONE, FL_DONE (flush in first DONE cycle), or MD_WAIT/ALU cycle index to flush in.
  task automatic do_op(input bit md, input logic [3:0] it, input logic [4:0] op,
                       input logic [31:0] pc, imm, a, b, mres,
                       input int dly, input int stall, input int fl);
    logic [31:0] exp_r;
    bit          exp_to;
    idu_valid_i = 1'b1; is_md_i = md; inst_type_i = it; alu_op_i = op;
    pc_i = pc; imm_i = imm; rdata1_i = a; rdata2_i = b;
    wbu_ready_i = 1'b0; md_done_i = 1'b0; flush_i = 1'b0;
    #1 chk("accept_ready", 32'(exu_ready_o), 32'd1);
    @(negedge clk);
    idu_valid_i = 1'b0;
    scramble();
    #1;
    chk("busy_ready", 32'(exu_ready_o), 32'd0);
    chk("lat_type", 32'(fu_inst_type_o), 32'(it));
    chk("lat_op", 32'(fu_alu_op_o), 32'(op));
    chk("lat_pc", fu_pc_o, pc);
    chk("lat_imm", fu_imm_o, imm);
    chk("lat_rs1", fu_rdata1_o, a);
    chk("lat_rs2", fu_rdata2_o, b);
    if (!md) begin
      exp_r = ref_result(it, op, pc, imm, a, b);
      exp_to = 1'b0;
      chk("alu_valid", 32'(wbu_valid_o), 32'd0);
      chk("alu_start", 32'(md_start_o), 32'd0);
      if (fl == 0) begin
        flush_i = 1'b1;
        #1 chk("alu_flush_kill", 32'(md_kill_o), 32'd0);
        @(negedge clk); flush_i = 1'b0;
        #1 chk("alu_flush_valid", 32'(wbu_valid_o), 32'd0);
        chk("alu_flush_ready", 32'(exu_ready_o), 32'd1);
        return;
      end
      @(negedge clk);
    end else begin
      for (int j = 0; j < 1000; j++) begin
        if (j == fl) begin
          flush_i = 1'b1; md_done_i = 1'($urandom_range(0, 1)); md_result_i = $urandom;
          #1 chk("md_flush_kill", 32'(md_kill_o), 32'd1);
          chk("md_flush_ready", 32'(exu_ready_o), 32'd0);
          @(negedge clk); flush_i = 1'b0; md_done_i = 1'b0;
          #1 chk("md_flush_valid", 32'(wbu_valid_o), 32'd0);
          chk("md_flush_idle", 32'(exu_ready_o), 32'd1);
          return;
        end
        md_done_i   = (j == dly);
        md_result_i = (j == dly) ? mres : $urandom;
        #1;
        chk("md_start", 32'(md_start_o), 32'(j == 0));
        chk("md_kill", 32'(md_kill_o), 32'(j == int'(MD_TO) - 1 && dly != j));
        chk("md_wait_valid", 32'(wbu_valid_o), 32'd0);
        @(negedge clk);
        md_done_i = 1'b0;
        if (j == dly || j == int'(MD_TO) - 1) break;
      end
      exp_r  = (dly < int'(MD_TO)) ? mres : 32'd0;
      exp_to = (dly >= int'(MD_TO));
    end
    for (int s = 0; s <= stall; s++) begin
      wbu_ready_i = (s == stall);
      if (fl == FL_DONE && s == 0) begin
        flush_i = 1'b1;
        wbu_ready_i = 1'($urandom_range(0, 1));
      end
      #1;
      chk("done_valid", 32'(wbu_valid_o), 32'd1);
      chk("done_result", result_o, exp_r);
      chk("done_timeout", 32'(timeout_o), 32'(exp_to));
      chk("done_ready", 32'(exu_ready_o), 32'd0);
      chk("done_kill", 32'(md_kill_o), 32'd0);
      @(negedge clk);
      if (flush_i) begin
        flush_i = 1'b0; wbu_ready_i = 1'b0;
        #1 chk("done_flush_valid", 32'(wbu_valid_o), 32'd0);
        chk("done_flush_idle", 32'(exu_ready_o), 32'd1);
        return;
      end
    end
    wbu_ready_i = 1'b0;
    #1 chk("wb_valid_drop", 32'(wbu_valid_o), 32'd0);
    chk("back_idle", 32'(exu_ready_o), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush_i = 1'b0; idu_valid_i = 1'b0; wbu_ready_i = 1'b0;
    md_done_i = 1'b0; md_result_i = '0;
    scramble();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 32'(exu_ready_o), 32'd1);
    chk("rst_valid", 32'(wbu_valid_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    chk("rst_type", 32'(fu_inst_type_o), 32'(T_NOP));
    chk("rst_start", 32'(md_start_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op(1'b0, T_RR, A_ADD, 32'h100, 32'h0, 32'd5, 32'd7, 32'h0, 0, 0, FL_NONE);
    do_op(1'b0, T_RR, A_SUB, 32'h104, 32'h0, 32'd3, 32'd9, 32'h0, 0, 5, FL_NONE);
    do_op(1'b1, T_RR, A_ADD, 32'h108, 32'h0, 32'd1, 32'd2, 32'hDEAD_BEEF, 10, 1, FL_NONE);
    do_op(1'b1, T_RR, A_ADD, 32'h10C, 32'h0, 32'd1, 32'd2, 32'h1234_5678, 1000, 0, FL_NONE);
    do_op(1'b1, T_RR, A_ADD, 32'h110, 32'h0, 32'd1, 32'd2, 32'h5555_AAAA, 63, 0, FL_NONE);
    do_op(1'b1, T_RR, A_XOR, 32'h114, 32'h0, 32'd1, 32'd2, 32'h0, 0, 0, FL_NONE);
    do_op(1'b1, T_RR, A_ADD, 32'h118, 32'h0, 32'd1, 32'd2, 32'h0, 1000, 0, 4);
    do_op(1'b0, T_RR, A_ADD, 32'h11C, 32'h0, 32'd4, 32'd4, 32'h0, 0, 2, FL_DONE);
    do_op(1'b0, T_NOP, A_ADD, 32'h120, 32'h0, 32'd4, 32'd4, 32'h0, 0, 0, FL_NONE);

    // Flush while IDLE must block the accept.
    idu_valid_i = 1'b1; flush_i = 1'b1;
    #1 chk("idle_flush_ready", 32'(exu_ready_o), 32'd0);
    @(negedge clk); idu_valid_i = 1'b0; flush_i = 1'b0;
    #1 chk("idle_flush_noacc", 32'(exu_ready_o), 32'd1);

    // Reset in the middle of MD_WAIT, then a clean AUIPC.
    idu_valid_i = 1'b1; is_md_i = 1'b1; inst_type_i = T_RR; alu_op_i = A_ADD;
    @(negedge clk); idu_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1 chk("rst_mid_kill", 32'(md_kill_o), 32'd0);
    @(negedge clk); rst = 1'b0;
    #1 chk("rst_mid_ready", 32'(exu_ready_o), 32'd1);
    chk("rst_mid_valid", 32'(wbu_valid_o), 32'd0);
    chk("rst_mid_type", 32'(fu_inst_type_o), 32'(T_NOP));
    chk("rst_mid_pc", fu_pc_o, 32'd0);
    chk("rst_mid_start", 32'(md_start_o), 32'd0);
    do_op(1'b0, T_AUIPC, A_ADD, 32'h8000_0000, 32'h1000, 32'd0, 32'd0, 32'h0, 0, 0, FL_NONE);

    for (int k = 0; k < 40; k++) begin
      bit          md;
      int          dly, stall, fl, sel;
      logic [3:0]  it;
      logic [4:0]  op;
      md    = 1'($urandom_range(0, 1));
      it    = 4'($urandom_range(0, 2));
      op    = 5'($urandom_range(0, 3));
      dly   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(58, 70)) : int'($urandom_range(0, 12));
      stall = int'($urandom_range(0, 3));
      sel   = int'($urandom_range(0, 9));
      fl    = FL_NONE;
      if (sel == 0) fl = FL_DONE;
      else if (sel == 1) begin
        if (!md) fl = 0;
        else if (dly >= 2) fl = int'($urandom_range(1, 32'(dly < int'(MD_TO) ? dly : int'(MD_TO) - 1)));
      end
      do_op(md, it, op, $urandom, $urandom, $urandom, $urandom, $urandom, dly, stall, fl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
